// File: rtl/cic_integ_decim_pkg.sv
// rtl/cic_integ_decim_pkg.sv - shared constants and helpers for the CIC integrator/decimator
//
// Default widths for the integrator/decimator front end, plus the two small helpers
// the datapath needs: sign extension to the accumulator width and the ratio
// sanitiser that maps a programmed ratio of 0 onto 1.
package cic_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_N_STAGES   = 3;
  localparam int DEF_R_WIDTH    = 4;

  // Widest value sext() can handle; callers size-cast down to their own width.
  localparam int SEXT_MAX = 64;

  // Sign-extend the low w bits of v across all SEXT_MAX bits. Done by shifting the
  // sign bit to the top and shifting back arithmetically, so any w is handled
  // without variable bit indexing.
  function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] v, input int w);
    logic signed [SEXT_MAX-1:0] t;
    t = $signed(v << (SEXT_MAX - w));
    return $unsigned(t >>> (SEXT_MAX - w));
  endfunction

  // Ratios 0 and 1 both mean "one output per input".
  function automatic int ratio_sanitise(input int r);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cic_integ_decim_if.sv
// rtl/cic_integ_decim_if.sv - sample/result bus between a driver and the integrator/decimator
//
// master : drives clear, in_valid, in, dec_ratio; observes out, out_valid
// slave  : the integrator/decimator itself
interface cic_integ_decim_if
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int R_WIDTH    = DEF_R_WIDTH
);
  logic                  clear;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in;
  logic [R_WIDTH-1:0]    dec_ratio;
  logic [ACC_WIDTH-1:0]  out;
  logic                  out_valid;

  modport master (
    output clear, in_valid, in, dec_ratio,
    input  out, out_valid
  );

  modport slave (
    input  clear, in_valid, in, dec_ratio,
    output out, out_valid
  );
endinterface

// File: rtl/cic_integ_decim_integrator.sv
// rtl/cic_integ_decim_integrator.sv - one registered wrap-around accumulator stage
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : accumulate add_in this cycle
//   clear      : synchronous zero, wins over en
//   add_in     : addend (already at WIDTH bits, two's complement)
//   acc        : registered accumulator value
module cic_integrator
  import cic_pkg::*;
#(
  parameter int WIDTH = DEF_ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] add_in,
  output logic [WIDTH-1:0] acc
);

  // Plain modular add: overflow wraps, which the downstream combs rely on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + add_in;
    end
  end

endmodule

// File: rtl/cic_integ_decim.sv
// rtl/cic_integ_decim.sv - CIC integrator cascade with programmable decimation
//
// Runs N_STAGES integrators at the input rate and emits the last stage's value once
// per r_active accepted samples, with a one-cycle out_valid strobe for the combs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of cic_integ_decim_if (clear, in_valid, in, dec_ratio
//                in; out, out_valid back)
module cic_integ_decim
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int N_STAGES   = DEF_N_STAGES,
  parameter int R_WIDTH    = DEF_R_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  cic_integ_decim_if.slave bus
);

  logic [ACC_WIDTH-1:0]                in_ext;
  logic [N_STAGES-1:0][ACC_WIDTH-1:0]  stage_add;
  logic [N_STAGES-1:0][ACC_WIDTH-1:0]  stage_acc;
  logic [ACC_WIDTH-1:0]                last_next;
  logic [R_WIDTH-1:0]                  cnt;
  logic [R_WIDTH-1:0]                  r_active;
  logic [R_WIDTH-1:0]                  ratio_next;
  logic                                tick;

  assign in_ext     = ACC_WIDTH'(sext(SEXT_MAX'(bus.in), DATA_WIDTH));
  assign ratio_next = R_WIDTH'(ratio_sanitise(32'(bus.dec_ratio)));

  // Each stage adds the pre-update value of the stage before it, which is what
  // gives the cascade its N_STAGES-1 sample impulse delay.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stage_add[k] = in_ext;
    end else begin : g_rest
      assign stage_add[k] = stage_acc[k-1];
    end

    cic_integrator #(.WIDTH(ACC_WIDTH)) u_integ (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (bus.in_valid),
      .clear  (bus.clear),
      .add_in (stage_add[k]),
      .acc    (stage_acc[k])
    );
  end

  // Value the last stage will hold after this edge; the output register captures
  // it so out lines up with the sample that completed the frame.
  assign last_next = stage_acc[N_STAGES-1] + stage_add[N_STAGES-1];

  assign tick = bus.in_valid && !bus.clear && (cnt == r_active - 1'b1);

  // r_active only reloads at a frame boundary or clear, so a ratio change never
  // shortens the frame already in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      r_active      <= R_WIDTH'(1);
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.clear) begin
      cnt           <= '0;
      r_active      <= ratio_next;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= tick;
      if (tick) begin
        cnt      <= '0;
        bus.out  <= last_next;
        r_active <= ratio_next;
      end else if (bus.in_valid) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cic_integ_decim.sv
// tb/tb_cic_integ_decim.sv - self-checking bench for cic_integ_decim (N=3/32-bit and N=1/16-bit builds)
module tb_cic_integ_decim;

  logic clk;
  logic rst_n;

  cic_integ_decim_if #(.DATA_WIDTH(16), .ACC_WIDTH(32), .R_WIDTH(4)) bus_a ();
  cic_integ_decim_if #(.DATA_WIDTH(16), .ACC_WIDTH(16), .R_WIDTH(4)) bus_b ();

  cic_integ_decim #(.DATA_WIDTH(16), .ACC_WIDTH(32), .N_STAGES(3), .R_WIDTH(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  cic_integ_decim #(.DATA_WIDTH(16), .ACC_WIDTH(16), .N_STAGES(1), .R_WIDTH(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: samples accepted since the last clear/reset; an output is the
  // N-fold running sum of that history, i.e. sum of C(n-i, N-1) * x[i].
  longint hist[$];
  int     cnt_m;
  int     r_m;
  bit     ev;
  longint eo_a;
  longint eo_b;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint binom(input int a, input int b);
    longint r;
    if (a < b) return 0;
    r = 1;
    for (int j = 1; j <= b; j++) r = r * (a - b + j) / j;
    return r;
  endfunction

  function automatic longint wsum(input int n_st, input int w);
    longint s;
    int n;
    s = 0;
    n = hist.size() - 1;
    for (int i = 0; i <= n; i++) s += binom(n - i, n_st - 1) * hist[i];
    return s & ((longint'(1) << w) - 1);
  endfunction

  function automatic int san(input logic [3:0] r);
    return (r == 0) ? 1 : int'(r);
  endfunction

  task automatic model_reset();
    hist.delete();
    cnt_m = 0;
    r_m   = 1;
    ev    = 0;
    eo_a  = 0;
    eo_b  = 0;
  endtask

  // Drive one cycle of inputs on both builds, advance the model, then check.
  task automatic step(input bit clr, input bit v, input logic [15:0] d, input logic [3:0] ratio);
    bus_a.clear = clr;  bus_a.in_valid = v;  bus_a.in = d;  bus_a.dec_ratio = ratio;
    bus_b.clear = clr;  bus_b.in_valid = v;  bus_b.in = d;  bus_b.dec_ratio = ratio;
    ev = 0;
    if (clr) begin
      hist.delete();
      cnt_m = 0;
      r_m   = san(ratio);
    end else if (v) begin
      hist.push_back(longint'($signed(d)));
      if (cnt_m == r_m - 1) begin
        ev    = 1;
        eo_a  = wsum(3, 32);
        eo_b  = wsum(1, 16);
        cnt_m = 0;
        r_m   = san(ratio);
      end else begin
        cnt_m++;
      end
    end
    @(posedge clk);
    #1;
    chk("a_out_valid", longint'(bus_a.out_valid), longint'(ev));
    chk("b_out_valid", longint'(bus_b.out_valid), longint'(ev));
    chk("a_out", longint'(bus_a.out), eo_a);
    chk("b_out", longint'(bus_b.out), eo_b);
  endtask

  longint imp_exp[7] = '{0, 0, 1, 3, 6, 10, 15};

  initial begin
    rst_n = 1'b0;
    bus_a.clear = 0; bus_a.in_valid = 0; bus_a.in = '0; bus_a.dec_ratio = '0;
    bus_b.clear = 0; bus_b.in_valid = 0; bus_b.in = '0; bus_b.dec_ratio = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_a_out", longint'(bus_a.out), 0);
    chk("rst_a_valid", longint'(bus_a.out_valid), 0);
    chk("rst_b_out", longint'(bus_b.out), 0);
    chk("rst_b_valid", longint'(bus_b.out_valid), 0);
    rst_n = 1'b1;

    // Impulse through the 3-stage build at R=1.
    step(1, 0, 0, 1);
    for (int j = 0; j < 7; j++) begin
      step(0, 1, (j == 0) ? 16'd1 : 16'd0, 1);
      chk("impulse_a", longint'(bus_a.out), imp_exp[j]);
    end
    step(0, 0, 0, 1);

    // Step input, R=4: 1-stage build yields 8,16,24.
    step(1, 0, 0, 4);
    for (int j = 1; j <= 12; j++) begin
      step(0, 1, 16'd2, 4);
      if (j % 4 == 0) chk("step_b", longint'(bus_b.out), longint'(2 * j));
    end

    // Same step with a gap after every sample.
    step(1, 0, 0, 4);
    for (int j = 1; j <= 8; j++) begin
      step(0, 1, 16'd2, 4);
      step(0, 0, 16'd9, 4);
      if (j % 4 == 0) chk("gap_b_hold", longint'(bus_b.out), longint'(2 * j));
    end

    // Wrap-around in the 16-bit build.
    step(1, 0, 0, 1);
    step(0, 1, 16'h7FFF, 1);
    chk("wrap1_b", longint'(bus_b.out), 64'h7FFF);
    step(0, 1, 16'h7FFF, 1);
    chk("wrap2_b", longint'(bus_b.out), 64'hFFFE);

    // Ratio change mid-frame, then clear mid-frame.
    step(1, 0, 0, 4);
    step(0, 1, 16'd3, 4);
    for (int j = 0; j < 7; j++) step(0, 1, 16'd3, 2);
    step(1, 1, 16'd7, 2);
    step(0, 1, 16'd3, 2);
    step(0, 1, 16'd3, 2);

    // Reset mid-frame with cnt at 2.
    step(1, 0, 0, 4);
    step(0, 1, 16'd5, 4);
    step(0, 1, 16'd5, 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_a_out", longint'(bus_a.out), 0);
    chk("midrst_a_valid", longint'(bus_a.out_valid), 0);
    chk("midrst_b_out", longint'(bus_b.out), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 9; j++) step(0, 1, 16'd5, 4);

    // Randomised traffic.
    begin
      logic [3:0] rr;
      rr = 4'd3;
      for (int j = 0; j < 800; j++) begin
        if ($urandom_range(0, 19) == 0) rr = 4'($urandom_range(0, 15));
        step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, 16'($urandom), rr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
